instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have the parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have the parameter NOP_INSTR, default 32'h0000_0000, giving the bubble word inserted into IF/ID on a flush.
REQ-003 The block SHALL have the port Clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port Reset, input, 1 bit; reset is asynchronous and active-low.
REQ-005 The block SHALL have the port pc_load, input, 1 bit, from the control unit: 1 = advance, 0 = stall.
REQ-006 The block SHALL have the port Jump, input, 2 bits, from the control unit: 00 none, 01 j/jal, 10 jr, 11 reserved.
REQ-007 The block SHALL have the port jr_target, input, 32 bits, the register value used for jr.
REQ-008 The block SHALL have the port branch_taken, input, 1 bit, the branch resolved in EX.
REQ-009 The block SHALL have the port branch_target, input, 32 bits, the EX-computed branch address.
REQ-010 The block SHALL have the port imem_addr, output, 32 bits, the instruction-memory address (equals pc).
REQ-011 The block SHALL have the port imem_rdata, input, 32 bits, the combinational instruction-memory read data.
REQ-012 The block SHALL have the port pc, output, 32 bits, the current fetch PC.
REQ-013 The block SHALL have the port instr, output, 32 bits, the IF/ID instruction.
REQ-014 The block SHALL have the ports opcode and funct, outputs, 6 bits each: instr[31:26] and instr[5:0], feeding the control unit.
REQ-015 The block SHALL have the port if_id_pc_plus4, output, 32 bits, PC+4 of the IF/ID instruction (jal link value).
REQ-016 The block SHALL have the port if_id_valid, output, 1 bit; 0 marks a bubble.
REQ-017 The block SHALL have the port flush_id, output, 1 bit, combinational, equal to branch_taken, telling downstream to squash ID/EX.

Function
REQ-018 The next PC SHALL be chosen by priority: branch_taken -> branch_target; else Jump==01 -> {if_id_pc_plus4[31:28], instr[25:0], 2'b00}; else Jump==10 -> jr_target; else pc_load==0 -> hold; else pc+4.
REQ-019 Jump==11 SHALL be treated as 00.
REQ-020 A Jump redirect SHALL apply only when if_id_valid==1; when if_id_valid==0, Jump SHALL be ignored.
REQ-021 On a redirect edge, IF/ID SHALL load NOP_INSTR with if_id_valid=0; the redirect costs exactly one bubble.
REQ-022 A redirect SHALL override pc_load==0, so a flush wins over a stall.
REQ-023 On a normal edge (no redirect, pc_load=1), IF/ID SHALL load imem_rdata, pc+4, and valid=1.
REQ-024 On a stall edge (no redirect, pc_load=0), pc and all of IF/ID SHALL hold.
REQ-025 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-026 Bits [1:0] of all targets SHALL be forced to 00.
REQ-027 Fetch latency SHALL be one cycle: the word at pc appears on instr after the next edge.

Reset
REQ-028 Reset low SHALL immediately set pc=RESET_PC, instr=NOP_INSTR, if_id_pc_plus4=0, and if_id_valid=0, independent of Clock.
REQ-029 On the first edge after Reset deasserts, normal fetch from RESET_PC SHALL occur.
REQ-030 Reset asserted mid-stall or mid-redirect SHALL discard the pending action.

Structure
REQ-031 The shared package mips_pkg SHALL hold the constants JUMP_NONE/JUMP_J/JUMP_JR, NOP_INSTR, and the opcode/funct field positions.
REQ-032 Next-PC selection SHALL be implemented in one combinational sub-module, pc_select; the PC and IF/ID registers SHALL stay in instruction_fetch.

Verification
REQ-033 Release reset with imem returning word = address -> pc sequence 0, 4, 8; instr = 0, 4 one cycle later, with if_id_valid=1.
REQ-034 Set pc_load=0 for 2 cycles at pc=8 -> pc stays 8 and instr/valid hold; on resume, pc=12.
REQ-035 With IF/ID holding j with target field 26'h40 and pc_plus4=32'h0000_0010 -> next pc=32'h0000_0100, IF/ID becomes a bubble, then instr=word@0x100.
REQ-036 Drive branch_taken=1 with branch_target=32'h200 while Jump=10 and pc_load=0 in the same cycle -> pc=32'h200, flush_id=1, IF/ID becomes a bubble.
REQ-037 Drive Jump=10 with jr_target=32'h0000_0033 -> pc=32'h0000_0030.
REQ-038 Assert Reset asynchronously mid-cycle at pc=32'hFFFF_FFFC -> pc=0 and valid=0 immediately; a separate run without reset wraps pc to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS front end: jump encodings,
// the bubble word and the instruction field positions.
package mips_pkg;

    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_J    = 2'b01;
    localparam logic [1:0] JUMP_JR   = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int INDEX_MSB = 25;

    // Targets are always word aligned; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_select.sv
// Next-PC selection: branch > j/jal > jr > stall > sequential.
// In: pc_load, jump, jr_target, branch_*, if_id_valid, j_index,
// pc_region, pc. Out: next_pc, redirect (IF/ID must bubble).
module pc_select
    import mips_pkg::*;
(
    input  logic        pc_load,
    input  logic [1:0]  jump,
    input  logic [31:0] jr_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        if_id_valid,
    input  logic [25:0] j_index,
    input  logic [3:0]  pc_region,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        redirect
);

    always_comb begin
        next_pc  = pc + 32'd4;
        redirect = 1'b0;
        // A jump held by a bubble is stale and must be ignored;
        // the reserved encoding 11 falls through as "no jump".
        if (branch_taken) begin
            next_pc  = word_align(branch_target);
            redirect = 1'b1;
        end else if (if_id_valid && jump == JUMP_J) begin
            next_pc  = {pc_region, j_index, 2'b00};
            redirect = 1'b1;
        end else if (if_id_valid && jump == JUMP_JR) begin
            next_pc  = word_align(jr_target);
            redirect = 1'b1;
        end else if (!pc_load) begin
            next_pc = pc;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC register, IF/ID pipeline register, redirect bubbles.
// In: Clock, Reset(n), pc_load, Jump, jr_target, branch_*, imem_rdata.
// Out: imem_addr, pc, instr, opcode, funct, if_id_pc_plus4,
// if_id_valid, flush_id.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        pc_load,
    input  logic [1:0]  Jump,
    input  logic [31:0] jr_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        flush_id
);

    import mips_pkg::OPC_MSB;
    import mips_pkg::OPC_LSB;
    import mips_pkg::FUNCT_MSB;
    import mips_pkg::FUNCT_LSB;
    import mips_pkg::INDEX_MSB;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] next_pc;
    logic        redirect;

    pc_select u_pc_select (
        .pc_load       (pc_load),
        .jump          (Jump),
        .jr_target     (jr_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_id_valid   (valid_q),
        .j_index       (instr_q[INDEX_MSB:0]),
        .pc_region     (pc4_q[31:28]),
        .pc            (pc_q),
        .next_pc       (next_pc),
        .redirect      (redirect)
    );

    always_comb begin
        pc_d    = next_pc;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        // A redirect beats a stall: the wrong-path word becomes
        // a bubble; the link value is kept since it is don't-care.
        if (redirect) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (pc_load) begin
            instr_d = imem_rdata;
            pc4_d   = pc_q + 32'd4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign pc             = pc_q;
    assign imem_addr      = pc_q;
    assign instr          = instr_q;
    assign opcode         = instr_q[OPC_MSB:OPC_LSB];
    assign funct          = instr_q[FUNCT_MSB:FUNCT_LSB];
    assign if_id_pc_plus4 = pc4_q;
    assign if_id_valid    = valid_q;
    assign flush_id       = branch_taken;

endmodule
